edge_event_arbiter: RTL
=======================

# edge_event_arbiter

Multi-channel edge-event collector and scheduler. Synchronises N_CH asynchronous inputs and detects rising and falling edges on each. Holds one pending event per channel and serialises the events onto a single valid/ready event port using round-robin arbitration. It sits between raw external strobes and the downstream event consumer (interrupt/status logic). Per-channel sticky overflow flags report dropped events.

## Interface
- N_CH, 4: number of input channels (2..16)
- SYNC_STAGES, 2: synchroniser flops per input (≥2)
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- in_a  input  N_CH  raw asynchronous channel inputs
- ch_en  input  N_CH  per-channel enable
- evt_valid  output  1  event present on output port
- evt_ready  input  1  consumer accepts event
- evt_ch  output  $clog2(N_CH)  channel index of presented event
- evt_rise  output  1  presented event is a rising edge
- evt_fall  output  1  presented event is a falling edge (exactly one of rise/fall set while evt_valid)
- ovf  output  N_CH  sticky per-channel overflow flags
- ovf_clr  input  1  synchronous clear of all ovf bits

## Operation
- Reset: sync chains, previous-level registers, pending slots, evt_valid, evt_ch, evt_rise, evt_fall and ovf all 0. RR pointer = N_CH-1, so channel 0 has priority first.
- Per channel: SYNC_STAGES-flop synchroniser → s. Register s_d <= s. rise_det = s & ~s_d; fall_det = ~s & s_d.
- An input held high through reset produces one rise event after sync latency.
- Pending slot per channel: pend[i] plus pend_type[i] (1 = rise).
  - A detection with ch_en[i]=1 loads the slot.
- Output register (states EMPTY: evt_valid=0, FULL: evt_valid=1). Load condition: (!evt_valid | evt_ready) and any pend.
  - On load, winner = first pending channel at or after ptr+1 (mod N_CH).
  - Set evt_ch = winner, evt_rise/evt_fall from pend_type, evt_valid=1.
  - Clear pend[winner] and set ptr = winner.
- Accept with no pending: evt_valid -> 0 next cycle.
- Back-to-back: accept and reload happen in the same cycle, so throughput is 1 event/cycle.
- Outputs are stable while evt_valid & !evt_ready.
- Overflow:
  - A detection on channel i while pend[i]=1, and channel i not being loaded this cycle, drops the new edge and sets ovf[i].
  - If channel i is being loaded into the output register in the same cycle, the new edge fills the freed slot and there is no overflow.
- ch_en[i]=0: pend[i] cleared, detections ignored, ovf[i] unchanged. An event already in the output register is unaffected.
- ovf_clr clears all ovf bits. A same-cycle overflow set on bit i wins over the clear.
- Asynchronous reset mid-transfer drops all pending and presented events immediately. No event is presented until new edges arrive after reset release.

## Timing
- Define edge E0 as the first clk edge sampling the new in_a level.
- Detection is combinational after edge E0+SYNC_STAGES-1.
- pend sets at E0+SYNC_STAGES.
- evt_valid rises after E0+SYNC_STAGES+1 if the output register is free and no other channel wins.
- Latency is SYNC_STAGES+2 edges in total (4 for default).
- Input pulses shorter than 1 clk period may be missed. The minimum guaranteed-detected level duration is 2 clk periods.
- Opposite edges on one channel closer than the drain time overflow. Events are never reordered within a channel.
- Valid/ready: once evt_valid rises it stays high until evt_ready is sampled high. evt_ready while evt_valid=0 is ignored.

## Test plan
- Single rise: reset, ch_en=4'hF, in_a[2] 0→1 at E0, evt_ready=1 → evt_valid=1 after E0+3 edges with evt_ch=2, evt_rise=1 for one cycle; ovf=0.
- Round robin: rising edges on channels 0,1,3 in the same cycle, evt_ready=1 → events ch0, ch1, ch3 on consecutive cycles. Then same-cycle edges on ch1 and ch3 (ptr=3) → ch1 then ch3.
- Backpressure: evt_ready=0, rise on ch0 then fall on ch0 four cycles later → output holds ch0 rise unchanged. The fall fills the freed slot without overflow. A further rise 4 cycles later sets ovf[0]=1 and is dropped. Release ready → ch0 rise, then ch0 fall; ovf stays 1 until ovf_clr.
- Disable: pend ch1 with ready=0, drop ch_en[1] → after ready=1 only the already-presented event emerges. Edges on ch1 while ch_en[1]=0 produce nothing.
- Reset mid-operation: evt_valid=1 with two pending, assert rst_n=0 mid-cycle → evt_valid, ovf, pend go 0 immediately. No events after release until new edges.
- ovf_clr collision: overflow on ch3 in the same cycle as ovf_clr=1 → ovf[3]=1, all other bits 0.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter
//
// Collects rising/falling edge events from N_CH asynchronous strobes. It holds
// one pending event per channel and serialises the events onto a single
// valid/ready port with round-robin arbitration. Per-channel sticky overflow
// flags record edges that were dropped because the channel's slot was full.
//
// Ports
//   clk          : clock
//   rst_n        : asynchronous active-low reset
//   in_a_i       : raw asynchronous channel inputs          [N_CH]
//   ch_en_i      : per-channel enable                       [N_CH]
//   evt_valid_o  : event present on output port
//   evt_ready_i  : consumer accepts the presented event
//   evt_ch_o     : channel index of the presented event     [CH_W]
//   evt_rise_o   : presented event is a rising edge
//   evt_fall_o   : presented event is a falling edge
//   ovf_o        : sticky per-channel overflow flags        [N_CH]
//   ovf_clr_i    : synchronous clear of all overflow flags
//
// Output register FSM
//   state | meaning
//   ------+---------------------------------------------
//   EMPTY | no event presented, evt_valid_o = 0
//   FULL  | event presented and held until accepted
// -----------------------------------------------------------------------------
module edge_event_arbiter #(
    parameter  int N_CH        = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int CH_W        = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] in_a_i,
    input  logic [N_CH-1:0] ch_en_i,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [CH_W-1:0] evt_ch_o,
    output logic            evt_rise_o,
    output logic            evt_fall_o,
    output logic [N_CH-1:0] ovf_o,
    input  logic            ovf_clr_i
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e          state_q, state_d;

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] s_c;
    logic [N_CH-1:0] prev_q;
    logic [N_CH-1:0] rise_det_c, fall_det_c, det_c;

    logic [N_CH-1:0] pend_q, pend_d;
    logic [N_CH-1:0] pend_type_q, pend_type_d;
    logic [N_CH-1:0] ovf_q, ovf_d;
    logic [N_CH-1:0] req_c;

    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [CH_W-1:0] win_c;
    logic            load_c;

    logic [CH_W-1:0] evt_ch_q, evt_ch_d;
    logic            evt_rise_q, evt_rise_d;
    logic            evt_fall_q, evt_fall_d;

    // ------------------------------------------------------------------
    // Synchroniser chain and edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= in_a_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q <= s_c;
        end
    end

    assign s_c        = sync_q[SYNC_STAGES-1];
    assign rise_det_c = s_c & ~prev_q;
    assign fall_det_c = ~s_c & prev_q;
    assign det_c      = rise_det_c | fall_det_c;

    // A slot whose channel has just been disabled must not win, even though
    // its pend bit only clears on the next edge.
    assign req_c  = pend_q & ch_en_i;
    assign load_c = ((state_q == EMPTY) || evt_ready_i) && (|req_c);

    // ------------------------------------------------------------------
    // Round-robin winner: first requester at or after ptr+1 (mod N_CH)
    // ------------------------------------------------------------------
    always_comb begin
        logic            found;
        logic [CH_W-1:0] idx;
        win_c = '0;
        found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = CH_W'((int'(ptr_q) + k) % N_CH);
            if (!found && req_c[idx]) begin
                found = 1'b1;
                win_c = idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending slots and overflow flags
    // ------------------------------------------------------------------
    always_comb begin
        logic taken;
        pend_d      = pend_q;
        pend_type_d = pend_type_q;
        ovf_d       = ovf_clr_i ? '0 : ovf_q;
        for (int i = 0; i < N_CH; i++) begin
            taken = load_c && (win_c == CH_W'(i));
            if (!ch_en_i[i]) begin
                pend_d[i] = 1'b0;
                // flag keeps its value (subject only to ovf_clr_i)
            end else if (det_c[i]) begin
                // A slot being drained this cycle is free for the new edge.
                if (!pend_q[i] || taken) begin
                    pend_d[i]      = 1'b1;
                    pend_type_d[i] = rise_det_c[i];
                end else begin
                    // Set wins over a same-cycle clear.
                    ovf_d[i] = 1'b1;
                end
            end else if (taken) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            pend_type_q <= '0;
            ovf_q       <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_type_q <= pend_type_d;
            ovf_q       <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Output register FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (load_c) state_d = FULL;
            FULL:  if (evt_ready_i && !load_c) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        evt_valid_o = (state_q == FULL);
    end

    // ------------------------------------------------------------------
    // Presented event payload and RR pointer
    // ------------------------------------------------------------------
    always_comb begin
        evt_ch_d   = evt_ch_q;
        evt_rise_d = evt_rise_q;
        evt_fall_d = evt_fall_q;
        ptr_d      = ptr_q;
        if (load_c) begin
            evt_ch_d   = win_c;
            evt_rise_d = pend_type_q[win_c];
            evt_fall_d = ~pend_type_q[win_c];
            ptr_d      = win_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_ch_q   <= '0;
            evt_rise_q <= 1'b0;
            evt_fall_q <= 1'b0;
            ptr_q      <= CH_W'(N_CH - 1);
        end else begin
            evt_ch_q   <= evt_ch_d;
            evt_rise_q <= evt_rise_d;
            evt_fall_q <= evt_fall_d;
            ptr_q      <= ptr_d;
        end
    end

    assign evt_ch_o   = evt_ch_q;
    assign evt_rise_o = evt_rise_q;
    assign evt_fall_o = evt_fall_q;
    assign ovf_o      = ovf_q;

endmodule
